uart_loader: RTL
================

# uart_loader

Boot-time firmware loader sitting upstream of the SoC's dual-port word RAM and CPU core. It receives a framed image over a UART line, writes it word-by-word into RAM through the data-side write port, and holds the CPU in reset until the image is verified. If no frame arrives within a timeout, it releases the CPU to run the RAM's preloaded image.

## Interface
Parameters:
- CLKS_PER_BIT, 217: clk cycles per UART bit (25 MHz / 115200).
- BOOT_TIMEOUT, 25_000_000: cycles to wait for a magic byte after reset before releasing the CPU.
- MEM_WORDS, 4096: RAM capacity in 32-bit words (16 KiB).
- ADDR_WIDTH, 14: RAM byte-address width.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- uart_rx  in  1  asynchronous serial input, idle high, 8N1.
- mem_addr  out  ADDR_WIDTH  byte address of word write (always 4-aligned).
- mem_wdata  out  32  word to write.
- mem_wenable  out  4  byte enables; 4'b1111 for one cycle per word, else 0.
- cpu_hold  out  1  high keeps CPU in reset (drives CPU rst_n inverted).
- busy  out  1  high while a frame is in progress.
- error  out  1  sticky high after a failed frame until next successful frame or rst.

## Operation
- Frame: 0xA5 magic, LEN_LO, LEN_HI (word count, little-endian), LEN×4 payload bytes (each word little-endian), CHK = XOR of all payload bytes.
- RX: 2-flop synchronizer; start detected on falling edge; re-sampled at half bit (low required, else abort to idle, no byte); 8 data bits LSB-first sampled at mid-bit; stop bit sampled at mid-bit. Stop=0 → framing error pulse, no byte. Valid byte → 1-cycle byte_valid with byte.
- FSM states: WAIT_MAGIC, LEN_LO, LEN_HI, DATA, CHECK, RUN, ERROR.
- WAIT_MAGIC: non-0xA5 bytes ignored. 0xA5 → LEN_LO, cpu_hold=1, busy=1. Timeout counter runs only while armed (from rst until first magic); expiry → RUN.
- LEN_HI: LEN > MEM_WORDS → ERROR; LEN = 0 → CHECK; else DATA with word_idx=0, byte_idx=0, chk=0.
- DATA: byte shifted into wdata at byte_idx×8; chk ^= byte. On byte_idx=3: write strobe, word_idx++, byte_idx=0; word_idx reaching LEN → CHECK.
- CHECK: byte==chk → RUN, error=0; else ERROR.
- RUN: cpu_hold=0, busy=0. A new 0xA5 re-enters LEN_LO with cpu_hold=1 (reload while running permitted).
- ERROR: error=1, cpu_hold=1, busy=0, timeout disarmed; next cycle → WAIT_MAGIC (CPU stays held until a good frame).
- Framing error in any state other than WAIT_MAGIC/RUN → ERROR.
- Reset values: mem_addr=0, mem_wdata=0, mem_wenable=0, cpu_hold=1, busy=0, error=0; FSM WAIT_MAGIC, timeout armed at 0, RX idle.

## Timing
- byte_valid asserts the cycle after the stop-bit mid-sample.
- Word write: mem_wenable=4'b1111 exactly one cycle, cycle after 4th byte's byte_valid; mem_addr = word_idx×4 (pre-increment), mem_wdata = assembled word, both stable that cycle.
- cpu_hold falls the cycle after CHK byte_valid (match) or the cycle after timeout counter reaches BOOT_TIMEOUT−1.
- rst mid-frame: immediate return to reset values; partially written RAM not rolled back.
- word_idx wraps never: LEN ≤ MEM_WORDS enforced before DATA.

## Structure
- Shared package: frame magic 0xA5, FSM state encoding, default CLKS_PER_BIT.
- Sub-module uart_rx (synchronizer, bit timing, byte_valid/frame_err outputs); uart_loader holds FSM, counters, checksum, write port.

## Test plan
- Bytes A5 02 00 78 56 34 12 EF BE AD DE, CHK=0x00^…(computed) → writes 0x12345678 @0, 0xDEADBEEF @4, one-cycle enables, cpu_hold falls after CHK, error=0.
- Same frame with CHK off by one → no cpu_hold release, error=1, state back to WAIT_MAGIC; resend correct frame → error=0, cpu_hold=0.
- No input, BOOT_TIMEOUT=1000 → cpu_hold=1 through cycle 999, 0 from cycle 1000; mem_wenable never asserts.
- A5 01 10 (LEN=4097) → ERROR, no writes, cpu_hold=1.
- Stop bit forced 0 during payload byte → ERROR, no write for that word.
- rst asserted mid-DATA after 2 bytes → all outputs at reset values next cycle; new full frame loads correctly.

Source files
------------

// File: rtl/uart_loader_pkg.sv
// Shared definitions for the UART boot loader: frame magic, FSM encodings
// and the default bit timing.
package uart_loader_pkg;

  localparam logic [7:0] FRAME_MAGIC          = 8'hA5;
  localparam int         DEFAULT_CLKS_PER_BIT = 217;

  typedef enum logic [2:0] {
    WAIT_MAGIC,
    LEN_LO,
    LEN_HI,
    DATA,
    CHECK,
    RUN,
    ERROR
  } ldr_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_loader_if.sv
// Word write port from the loader into the data side of the dual-port RAM.
interface uart_loader_if #(
  parameter int ADDR_WIDTH = 14
);

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic [3:0]            mem_wenable;

  modport master (output mem_addr, mem_wdata, mem_wenable);
  modport slave  (input  mem_addr, mem_wdata, mem_wenable);

endinterface

// File: rtl/uart_loader_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, falling-edge start detect,
// mid-bit sampling; emits a one-cycle byte_valid or frame_err per character.
module uart_rx
  import uart_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       frame_err
);

  localparam int             CW   = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0]  HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]  FULL = CW'(CLKS_PER_BIT - 1);

  logic [1:0]    sync;
  logic          prev;
  rx_state_t     state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync       <= '1;
      prev       <= 1'b1;
      state      <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      sync       <= {sync[0], rx};
      prev       <= sync[1];
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (prev && !sync[1]) begin
            state <= RX_START;
            cnt   <= '0;
          end
        end
        RX_START: begin
          // A high line at mid-start is treated as a glitch, not a character.
          if (cnt == HALF) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= sync[1] ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == FULL) begin
            cnt   <= '0;
            shreg <= {sync[1], shreg[7:1]};
            if (bit_idx == 3'd7) state <= RX_STOP;
            else                 bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt == FULL) begin
            cnt   <= '0;
            state <= RX_IDLE;
            if (sync[1]) begin
              rx_byte    <= shreg;
              byte_valid <= 1'b1;
            end else begin
              frame_err  <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_loader.sv
// Boot loader: parses A5/LEN/payload/CHK frames from the UART, writes words
// into RAM and holds the CPU in reset until a frame verifies or boot times out.
module uart_loader
  import uart_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int BOOT_TIMEOUT = 25_000_000,
  parameter int MEM_WORDS    = 4096,
  parameter int ADDR_WIDTH   = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             uart_rx,
  uart_loader_if.master    mem,
  output logic             cpu_hold,
  output logic             busy,
  output logic             error
);

  localparam logic [31:0] TMO_LAST = 32'(BOOT_TIMEOUT - 1);
  localparam logic [16:0] MAX_LEN  = 17'(MEM_WORDS);

  logic       byte_valid;
  logic [7:0] rx_byte;
  logic       frame_err;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk        (clk),
    .rst        (rst),
    .rx         (uart_rx),
    .byte_valid (byte_valid),
    .rx_byte    (rx_byte),
    .frame_err  (frame_err)
  );

  ldr_state_t  state;
  logic [15:0] len;
  logic [15:0] word_idx;
  logic [1:0]  byte_idx;
  logic [7:0]  chk;
  logic        armed;
  logic [31:0] tcnt;
  logic        err_event;
  logic        is_magic;

  assign is_magic = byte_valid && (rx_byte == FRAME_MAGIC);

  always_comb begin
    err_event = 1'b0;
    if (frame_err && (state inside {LEN_LO, LEN_HI, DATA, CHECK, ERROR}))
      err_event = 1'b1;
    if (byte_valid && state == LEN_HI && {1'b0, rx_byte, len[7:0]} > MAX_LEN)
      err_event = 1'b1;
    if (byte_valid && state == CHECK && rx_byte != chk)
      err_event = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= WAIT_MAGIC;
      mem.mem_addr    <= '0;
      mem.mem_wdata   <= '0;
      mem.mem_wenable <= '0;
      cpu_hold        <= 1'b1;
      busy            <= 1'b0;
      error           <= 1'b0;
      len             <= '0;
      word_idx        <= '0;
      byte_idx        <= '0;
      chk             <= '0;
      armed           <= 1'b1;
      tcnt            <= '0;
    end else begin
      mem.mem_wenable <= '0;
      if (err_event) begin
        state    <= ERROR;
        error    <= 1'b1;
        cpu_hold <= 1'b1;
        busy     <= 1'b0;
        armed    <= 1'b0;
      end else begin
        case (state)
          WAIT_MAGIC: begin
            if (is_magic) begin
              state    <= LEN_LO;
              cpu_hold <= 1'b1;
              busy     <= 1'b1;
              armed    <= 1'b0;
            end else if (armed && tcnt == TMO_LAST) begin
              state    <= RUN;
              cpu_hold <= 1'b0;
              armed    <= 1'b0;
            end else if (armed) begin
              tcnt <= tcnt + 1'b1;
            end
          end
          LEN_LO: begin
            if (byte_valid) begin
              len[7:0] <= rx_byte;
              state    <= LEN_HI;
            end
          end
          LEN_HI: begin
            if (byte_valid) begin
              len      <= {rx_byte, len[7:0]};
              word_idx <= '0;
              byte_idx <= '0;
              chk      <= '0;
              state    <= ({rx_byte, len[7:0]} == 16'd0) ? CHECK : DATA;
            end
          end
          DATA: begin
            if (byte_valid) begin
              mem.mem_wdata[{byte_idx, 3'b000} +: 8] <= rx_byte;
              chk      <= chk ^ rx_byte;
              byte_idx <= byte_idx + 1'b1;
              if (byte_idx == 2'd3) begin
                mem.mem_wenable <= '1;
                mem.mem_addr    <= {word_idx[ADDR_WIDTH-3:0], 2'b00};
                word_idx        <= word_idx + 1'b1;
                if (16'(word_idx + 16'd1) == len) state <= CHECK;
              end
            end
          end
          CHECK: begin
            // A mismatching checksum is routed through err_event above.
            if (byte_valid) begin
              state    <= RUN;
              cpu_hold <= 1'b0;
              busy     <= 1'b0;
              error    <= 1'b0;
            end
          end
          RUN: begin
            if (is_magic) begin
              state    <= LEN_LO;
              cpu_hold <= 1'b1;
              busy     <= 1'b1;
            end
          end
          ERROR:   state <= WAIT_MAGIC;
          default: state <= WAIT_MAGIC;
        endcase
      end
    end
  end

endmodule
